sv32_ptw_walker: RTL and testbench

// Sv32 two-level page-table walker feeding the Sv32 TLB on a lookup miss. Accepts one miss
// (vaddr, ASID), fetches level-1 and, when needed, level-0 PTEs over a single-outstanding

---
 rtl/sv32_ptw_walker.sv | 182 ++++++++++++++++++
 tb/tb_sv32_ptw_walker.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv32_ptw_walker.sv
// ---------------------------------------------------------------------------
// sv32_ptw_walker
// Sv32 two-level hardware page-table walker. Takes one TLB miss at a time,
// reads the level-1 PTE (and the level-0 PTE when level 1 is a pointer) over
// a single-outstanding memory port, then pulses either a TLB update or a
// fault for exactly one cycle.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              abort the current walk; the aborted walk reports nothing
//   miss_*               miss request (valid/ready, vaddr, asid, root ppn)
//   mem_req_*            PTE read request (valid/ready, 34-bit physical address)
//   mem_rsp_*            PTE read response (valid, data, bus error)
//   update_o             {valid, is_4M, vpn[19:0], asid[8:0], pte[31:0]}
//   fault_o              one-cycle page/access fault pulse
//   busy_o               walk in progress
//
// state   | meaning
// IDLE    | ready for a miss (also during the update/fault pulse cycle)
// L1_REQ  | level-1 PTE request presented
// L1_WAIT | waiting for level-1 PTE
// L0_REQ  | level-0 PTE request presented
// L0_WAIT | waiting for level-0 PTE
// DRAIN   | walk aborted after its request went out; swallow one response
// ---------------------------------------------------------------------------
module sv32_ptw_walker #(
  parameter int ASID_WIDTH = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [31:0]           miss_vaddr_i,
  input  logic [ASID_WIDTH-1:0] miss_asid_i,
  input  logic [21:0]           satp_ppn_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [33:0]           mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [31:0]           mem_rsp_data_i,
  input  logic                  mem_rsp_err_i,
  output logic [62:0]           update_o,
  output logic                  fault_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_L1_REQ, S_L1_WAIT, S_L0_REQ, S_L0_WAIT, S_DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [19:0]             vpn_q, vpn_d;
  logic [ASID_WIDTH-1:0]   asid_q, asid_d;
  logic [21:0]             root_q, root_d;
  logic [21:0]             ppn_q, ppn_d;
  logic [62:0]             update_q, update_d;
  logic                    fault_q, fault_d;

  logic [8:0]              asid_ext;
  logic                    pte_v, pte_r, pte_w, pte_x;
  logic                    pte_bad, pte_leaf;
  logic                    unused_vaddr_lo;

  assign asid_ext        = 9'(asid_q);
  assign unused_vaddr_lo = ^miss_vaddr_i[11:0];

  assign pte_v    = mem_rsp_data_i[0];
  assign pte_r    = mem_rsp_data_i[1];
  assign pte_w    = mem_rsp_data_i[2];
  assign pte_x    = mem_rsp_data_i[3];
  // Bus error, not valid, or the reserved W-without-R encoding.
  assign pte_bad  = mem_rsp_err_i | ~pte_v | (~pte_r & pte_w);
  assign pte_leaf = pte_r | pte_x;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      vpn_q    <= '0;
      asid_q   <= '0;
      root_q   <= '0;
      ppn_q    <= '0;
      update_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vpn_q    <= vpn_d;
      asid_q   <= asid_d;
      root_q   <= root_d;
      ppn_q    <= ppn_d;
      update_q <= update_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    vpn_d    = vpn_q;
    asid_d   = asid_q;
    root_d   = root_q;
    ppn_d    = ppn_q;
    update_d = '0;
    fault_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (miss_valid_i && !flush_i) begin
          vpn_d   = miss_vaddr_i[31:12];
          asid_d  = miss_asid_i;
          root_d  = satp_ppn_i;
          state_d = S_L1_REQ;
        end
      end
      S_L1_REQ, S_L0_REQ: begin
        // A flush on the handshake cycle still leaves a response in flight.
        if (flush_i) begin
          state_d = mem_req_ready_i ? S_DRAIN : S_IDLE;
        end else if (mem_req_ready_i) begin
          state_d = (state_q == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
        end
      end
      S_L1_WAIT: begin
        if (mem_rsp_valid_i) begin
          state_d = S_IDLE;
          if (flush_i) begin
            state_d = S_IDLE;
          end else if (pte_bad) begin
            fault_d = 1'b1;
          end else if (pte_leaf) begin
            // A 4M leaf must have PPN[0] clear.
            if (mem_rsp_data_i[19:10] != 10'd0) begin
              fault_d = 1'b1;
            end else begin
              update_d = {1'b1, 1'b1, vpn_q, asid_ext, mem_rsp_data_i};
            end
          end else begin
            ppn_d   = mem_rsp_data_i[31:10];
            state_d = S_L0_REQ;
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_L0_WAIT: begin
        if (mem_rsp_valid_i) begin
          state_d = S_IDLE;
          if (flush_i) begin
            state_d = S_IDLE;
          end else if (pte_bad || !pte_leaf) begin
            fault_d = 1'b1;
          end else begin
            update_d = {1'b1, 1'b0, vpn_q, asid_ext, mem_rsp_data_i};
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_rsp_valid_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_addr_o = '0;
    if (state_q == S_L1_REQ) begin
      mem_req_addr_o = {root_q, vpn_q[19:10], 2'b00};
    end else if (state_q == S_L0_REQ) begin
      mem_req_addr_o = {ppn_q, vpn_q[9:0], 2'b00};
    end
  end

  assign mem_req_valid_o = (state_q == S_L1_REQ) || (state_q == S_L0_REQ);
  assign miss_ready_o    = (state_q == S_IDLE);
  assign busy_o          = (state_q != S_IDLE);
  assign update_o        = update_q;
  assign fault_o         = fault_q;

endmodule

// File: tb/tb_sv32_ptw_walker.sv
module tb_sv32_ptw_walker;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        miss_valid;
  logic        miss_ready;
  logic [31:0] miss_vaddr;
  logic [8:0]  miss_asid;
  logic [21:0] satp_ppn;
  logic        req_valid;
  logic        req_ready;
  logic [33:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [62:0] update;
  logic        fault;
  logic        busy;

  int total = 0;
  int bad   = 0;

  sv32_ptw_walker #(.ASID_WIDTH(9)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .miss_valid_i    (miss_valid),
    .miss_ready_o    (miss_ready),
    .miss_vaddr_i    (miss_vaddr),
    .miss_asid_i     (miss_asid),
    .satp_ppn_i      (satp_ppn),
    .mem_req_valid_o (req_valid),
    .mem_req_ready_i (req_ready),
    .mem_req_addr_o  (req_addr),
    .mem_rsp_valid_i (rsp_valid),
    .mem_rsp_data_i  (rsp_data),
    .mem_rsp_err_i   (rsp_err),
    .update_o        (update),
    .fault_o         (fault),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decide the walk outcome from the Sv32 PTE rules.
  function automatic void ref_walk(input logic [31:0] p1, input bit e1,
                                   input logic [31:0] p0, input bit e0,
                                   output int levels, output bit flt, output bit is4m);
    bit v, r, w, x;
    levels = 1; flt = 1'b0; is4m = 1'b0;
    {x, w, r, v} = p1[3:0];
    if (e1 || !v || (w && !r)) begin
      flt = 1'b1;
    end else if (r || x) begin
      is4m = 1'b1;
      flt  = (p1[19:10] != 10'd0);
    end else begin
      levels = 2;
      {x, w, r, v} = p0[3:0];
      flt = e0 || !v || (w && !r) || !(r || x);
    end
  endfunction

  task automatic check_idle_quiet(input string nm);
    total++;
    if (update !== 63'd0 || fault !== 1'b0 || miss_ready !== 1'b1 || busy !== 1'b0 || req_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s: update=%h fault=%b ready=%b busy=%b req_valid=%b, want all idle/zero",
               nm, update, fault, miss_ready, busy, req_valid);
    end
  endtask

  // Drives one full walk acting as the memory; called and returning at a negedge.
  task automatic run_walk(input logic [31:0] va, input logic [8:0] asid, input logic [21:0] satp,
                          input logic [31:0] p1, input bit e1, input logic [31:0] p0, input bit e0,
                          input int dly_rdy, input int dly_rsp, input string nm);
    int          levels;
    bit          flt, is4m;
    logic [33:0] exp_addr;
    logic [31:0] last_pte;
    logic [62:0] exp_upd;
    ref_walk(p1, e1, p0, e0, levels, flt, is4m);
    total++;
    if (miss_ready !== 1'b1) begin
      bad++; $display("FAIL %s accept: miss_ready=%b want 1", nm, miss_ready);
    end
    miss_valid = 1'b1; miss_vaddr = va; miss_asid = asid; satp_ppn = satp;
    @(negedge clk);
    miss_valid = 1'b0; miss_vaddr = $urandom; miss_asid = 9'($urandom); satp_ppn = 22'($urandom);
    last_pte = p1;
    for (int lv = 0; lv < levels; lv++) begin
      exp_addr = (lv == 0) ? {satp, va[31:22], 2'b00} : {p1[31:10], va[21:12], 2'b00};
      for (int k = 0; k <= dly_rdy; k++) begin
        total++;
        if (req_valid !== 1'b1 || req_addr !== exp_addr) begin
          bad++;
          $display("FAIL %s req L%0d: valid=%b addr=%h want 1/%h", nm, 1 - lv, req_valid, req_addr, exp_addr);
        end
        total++;
        if (miss_ready !== 1'b0 || busy !== 1'b1 || fault !== 1'b0 || update !== 63'd0) begin
          bad++;
          $display("FAIL %s busy L%0d: ready=%b busy=%b fault=%b upd=%h want 0/1/0/0",
                   nm, 1 - lv, miss_ready, busy, fault, update);
        end
        if (k == dly_rdy) req_ready = 1'b1;
        @(negedge clk);
      end
      req_ready = 1'b0;
      for (int k = 0; k < dly_rsp; k++) begin
        total++;
        if (req_valid !== 1'b0 || busy !== 1'b1) begin
          bad++; $display("FAIL %s wait: req_valid=%b busy=%b want 0/1", nm, req_valid, busy);
        end
        @(negedge clk);
      end
      rsp_valid = 1'b1;
      rsp_data  = (lv == 0) ? p1 : p0;
      rsp_err   = (lv == 0) ? e1 : e0;
      last_pte  = rsp_data;
      @(negedge clk);
      rsp_valid = 1'b0; rsp_err = 1'b0; rsp_data = $urandom;
    end
    exp_upd = flt ? 63'd0 : {1'b1, is4m, va[31:12], asid, last_pte};
    total++;
    if (fault !== flt || update !== exp_upd || miss_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s result: fault=%b update=%h ready=%b want %b/%h/1", nm, fault, update, miss_ready, flt, exp_upd);
    end
    @(negedge clk);
    check_idle_quiet({nm, " after pulse"});
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (miss_ready !== 1'b1 || req_valid !== 1'b0 || req_addr !== 34'd0 ||
        update !== 63'd0 || fault !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: ready=%b req_valid=%b addr=%h upd=%h fault=%b busy=%b want 1/0/0/0/0/0",
               miss_ready, req_valid, req_addr, update, fault, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_quiet("reset release");
  endtask

  task automatic test_4k_walk;
    run_walk(32'h0040_3000, 9'h001, 22'h00080, 32'h2000_0001, 1'b0, 32'h3000_00CF, 1'b0, 0, 0, "walk4k");
  endtask

  task automatic test_superpage;
    run_walk(32'h8000_0000, 9'h0A5, 22'h00080, 32'h1000_000F, 1'b0, 32'h0, 1'b0, 0, 0, "walk4m");
  endtask

  task automatic test_faults;
    run_walk(32'h1234_5000, 9'h003, 22'h00100, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 0, 0, "fault_v0");
    run_walk(32'h1234_5000, 9'h003, 22'h00100, 32'h0000_0407, 1'b0, 32'h0, 1'b0, 0, 0, "fault_misalign");
    run_walk(32'h1234_5000, 9'h003, 22'h00100, 32'h0000_0005, 1'b0, 32'h0, 1'b0, 0, 0, "fault_wnr");
    run_walk(32'h1234_5000, 9'h003, 22'h00100, 32'h2000_0001, 1'b0, 32'h2000_0001, 1'b0, 0, 0, "fault_l0ptr");
    run_walk(32'h1234_5000, 9'h003, 22'h00100, 32'h2000_0001, 1'b1, 32'h0, 1'b0, 0, 0, "fault_err_l1");
    run_walk(32'h1234_5000, 9'h003, 22'h00100, 32'h2000_0001, 1'b0, 32'h3000_00CF, 1'b1, 0, 0, "fault_err_l0");
  endtask

  task automatic test_backpressure;
    run_walk(32'h0040_3000, 9'h1FF, 22'h3ABCD, 32'h2000_0001, 1'b0, 32'h3000_00CB, 1'b0, 5, 1, "backpressure");
  endtask

  task automatic test_flush_wait;
    miss_valid = 1'b1; miss_vaddr = 32'h0040_3000; miss_asid = 9'h002; satp_ppn = 22'h00080;
    @(negedge clk);
    miss_valid = 1'b0; req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (busy !== 1'b1 || miss_ready !== 1'b0 || req_valid !== 1'b0 || fault !== 1'b0 || update !== 63'd0) begin
        bad++;
        $display("FAIL flush_wait drain: busy=%b ready=%b req=%b fault=%b upd=%h want 1/0/0/0/0",
                 busy, miss_ready, req_valid, fault, update);
      end
      @(negedge clk);
    end
    rsp_valid = 1'b1; rsp_data = 32'h1000_000F; rsp_err = 1'b0;
    @(negedge clk);
    rsp_valid = 1'b0;
    check_idle_quiet("flush_wait discard");
    @(negedge clk);
    check_idle_quiet("flush_wait quiet");
    run_walk(32'h0040_3000, 9'h001, 22'h00080, 32'h2000_0001, 1'b0, 32'h3000_00CF, 1'b0, 0, 0, "after_flush");
  endtask

  task automatic test_flush_req;
    miss_valid = 1'b1; miss_vaddr = 32'h0040_3000; miss_asid = 9'h002; satp_ppn = 22'h00080;
    @(negedge clk);
    miss_valid = 1'b0; req_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_idle_quiet("flush_req drop");
    // flush in IDLE blocks acceptance
    miss_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    miss_valid = 1'b0; flush = 1'b0;
    check_idle_quiet("flush_idle block");
  endtask

  task automatic test_async_reset;
    miss_valid = 1'b1; miss_vaddr = 32'h0040_3000; miss_asid = 9'h004; satp_ppn = 22'h00080;
    @(negedge clk);
    miss_valid = 1'b0; req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h2000_0001;
    @(negedge clk);
    rsp_valid = 1'b0; req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (miss_ready !== 1'b1 || req_valid !== 1'b0 || req_addr !== 34'd0 ||
        update !== 63'd0 || fault !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: ready=%b req_valid=%b addr=%h upd=%h fault=%b busy=%b want 1/0/0/0/0/0",
               miss_ready, req_valid, req_addr, update, fault, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b1; rsp_data = 32'h3000_00CF;
    @(negedge clk);
    rsp_valid = 1'b0;
    check_idle_quiet("late rsp ignored");
    @(negedge clk);
    check_idle_quiet("late rsp quiet");
  endtask

  task automatic test_random;
    logic [31:0] va, p1, p0;
    bit          e1, e0;
    for (int i = 0; i < 40; i++) begin
      va = $urandom;
      p1 = $urandom;
      p0 = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: p1[3:0] = 4'b0001;
        2: begin p1[19:10] = 10'd0; p1[1:0] = 2'b11; end
        default: p1[0] = 1'b1;
      endcase
      if ($urandom_range(0, 1) == 1) p0[1:0] = 2'b11;
      else p0[0] = ($urandom_range(0, 3) != 0);
      e1 = ($urandom_range(0, 9) == 0);
      e0 = ($urandom_range(0, 9) == 0);
      run_walk(va, 9'($urandom), 22'($urandom), p1, e1, p0, e0,
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; miss_valid = 1'b0; miss_vaddr = '0; miss_asid = '0;
    satp_ppn = '0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_4k_walk();
    test_superpage();
    test_faults();
    test_backpressure();
    test_flush_wait();
    test_flush_req();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
